// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master modport is the loader; the slave modport is the host plus the memory.
interface imem_loader_if #(
   parameter int AW = 8
);
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [15:0]   imem_wdata;

   modport master (
      input  in_data, in_valid,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Program loader: big-endian length + word stream into imem, holds the CPU in clear until done.
// Define LOADER_CSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for start
// LEN_HI  | expecting word count bits 15:8
// LEN_LO  | expecting word count bits 7:0, range-checked on accept
// DATA_HI | expecting high byte of next word
// DATA_LO | expecting low byte; write issued the following cycle
// CSUM    | expecting XOR of all stream bytes (LOADER_CSUM_EN only)
// DONE    | program loaded, CPU released
// ERR     | load aborted, CPU held in clear
module imem_loader #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          ce,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          cpu_clr,
   output logic          cpu_ce,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
`ifdef LOADER_CSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] CAP = 17'd1 << AW;

   state_t        state;
   logic          ready_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [15:0]   wdata_q;
   logic [15:0]   len;
   logic [7:0]    hi;
   logic [AW:0]   cnt;
`ifdef LOADER_CSUM_EN
   logic [7:0]    csum;
`endif

   logic          xfer;
   logic [15:0]   len_nx;
   logic [AW:0]   cnt_nx;
   logic          too_big;
   logic          last_word;

   assign bus.in_ready   = ready_q & ce;
   assign bus.imem_we    = we_q & ce;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;

   assign xfer      = bus.in_valid & bus.in_ready;
   assign len_nx    = {len[15:8], bus.in_data};
   assign cnt_nx    = cnt + {{AW{1'b0}}, 1'b1};
   assign too_big   = {1'b0, len_nx} > CAP;
   // Counter is one bit wider than the address so a full 2^AW load compares correctly.
   assign last_word = (17'(cnt_nx) == {1'b0, len});

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state   <= S_IDLE;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         len     <= '0;
         hi      <= '0;
         cnt     <= '0;
         cpu_clr <= 1'b1;
         cpu_ce  <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
`ifdef LOADER_CSUM_EN
         csum    <= '0;
`endif
      end else if (ce) begin
         we_q <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state   <= S_LEN_HI;
                  ready_q <= 1'b1;
                  cnt     <= '0;
                  cpu_clr <= 1'b1;
                  cpu_ce  <= 1'b0;
                  done    <= 1'b0;
                  err     <= 1'b0;
`ifdef LOADER_CSUM_EN
                  csum    <= '0;
`endif
               end
            end
            S_LEN_HI: begin
               if (xfer) begin
                  len[15:8] <= bus.in_data;
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (xfer) begin
                  len <= len_nx;
                  if (len_nx == 16'd0) begin
`ifdef LOADER_CSUM_EN
                     state   <= S_CSUM;
`else
                     state   <= S_DONE;
                     ready_q <= 1'b0;
                     done    <= 1'b1;
                     cpu_clr <= 1'b0;
                     cpu_ce  <= 1'b1;
`endif
                  end else if (too_big) begin
                     state   <= S_ERR;
                     ready_q <= 1'b0;
                     err     <= 1'b1;
                  end else begin
                     state <= S_DATA_HI;
                  end
               end
            end
            S_DATA_HI: begin
               if (xfer) begin
                  hi    <= bus.in_data;
                  state <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (xfer) begin
                  we_q    <= 1'b1;
                  addr_q  <= cnt[AW-1:0];
                  wdata_q <= {hi, bus.in_data};
                  cnt     <= cnt_nx;
                  if (last_word) begin
`ifdef LOADER_CSUM_EN
                     state   <= S_CSUM;
`else
                     // Release lands on the write edge, so the word is in memory before the first fetch.
                     state   <= S_DONE;
                     ready_q <= 1'b0;
                     done    <= 1'b1;
                     cpu_clr <= 1'b0;
                     cpu_ce  <= 1'b1;
`endif
                  end else begin
                     state <= S_DATA_HI;
                  end
               end
            end
`ifdef LOADER_CSUM_EN
            S_CSUM: begin
               if (xfer) begin
                  ready_q <= 1'b0;
                  if (bus.in_data == csum) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     cpu_clr <= 1'b0;
                     cpu_ce  <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state   <= S_IDLE;
               ready_q <= 1'b0;
            end
         endcase
`ifdef LOADER_CSUM_EN
         if (xfer && state != S_CSUM) csum <= csum ^ bus.in_data;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are sent and
// popped by a negedge monitor when the write strobe appears.
module tb_imem_loader;
   localparam int AW = 8;

   logic clk;
   logic clr_n;
   logic ce;
   logic start;
   logic cpu_clr;
   logic cpu_ce;
   logic done;
   logic err;

   imem_loader_if #(.AW(AW)) bus ();

   imem_loader #(.AW(AW)) dut (
      .clk     (clk),
      .clr_n   (clr_n),
      .ce      (ce),
      .start   (start),
      .bus     (bus),
      .cpu_clr (cpu_clr),
      .cpu_ce  (cpu_ce),
      .done    (done),
      .err     (err)
   );

   int checks = 0;
   int errors = 0;
   int n_writes = 0;
   logic prev_we = 1'b0;
   logic [7:0] xor_acc = 8'h00;
   logic [AW+15:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write monitor / scoreboard consumer
   always @(negedge clk) begin
      logic [AW+15:0] e;
      if (bus.imem_we === 1'b1) begin
         n_writes++;
         chk("we_single_cycle", 32'(prev_we), 32'd0);
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.imem_addr), 32'(e[AW+15:16]));
            chk("wr_data", 32'(bus.imem_wdata), 32'(e[15:0]));
         end
      end
      prev_we = bus.imem_we;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      xor_acc = 8'h00;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!(bus.in_ready === 1'b1 && ce === 1'b1) && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("hs_timeout", 32'(n >= 64), 32'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      xor_acc = xor_acc ^ b;
   endtask

   task automatic send_word(input logic [AW-1:0] a, input logic [15:0] d);
      send_byte(d[15:8]);
      exp_q.push_back({a, d});
      send_byte(d[7:0]);
   endtask

   task automatic finish_stream();
`ifdef LOADER_CSUM_EN
      logic [7:0] c;
      c = xor_acc;
      send_byte(c);
`endif
   endtask

   task automatic check_done(input string tag);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_cpu_clr"}, 32'(cpu_clr), 32'd0);
      chk({tag, "_cpu_ce"}, 32'(cpu_ce), 32'd1);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
   endtask

   task automatic check_err(input string tag);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd1);
      chk({tag, "_cpu_clr"}, 32'(cpu_clr), 32'd1);
      chk({tag, "_cpu_ce"}, 32'(cpu_ce), 32'd0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
      chk({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
      chk({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
      chk({tag, "_cpu_clr"}, 32'(cpu_clr), 32'd1);
      chk({tag, "_cpu_ce"}, 32'(cpu_ce), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic drain(input string tag, input int base, input int want);
      repeat (3) idle();
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_writes"}, 32'(n_writes - base), 32'(want));
   endtask

   initial begin
      int base;
      logic [15:0] d;
      clr_n        = 1'b0;
      ce           = 1'b1;
      start        = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      clr_n = 1'b1;
      idle();

      // 1: basic load, one byte per cycle
      base = n_writes;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h03);
      send_word(8'h00, 16'h1234);
      send_word(8'h01, 16'hABCD);
      send_word(8'h02, 16'h0001);
`ifndef LOADER_CSUM_EN
      chk("basic_we_with_done", 32'(bus.imem_we), 32'd1);
`endif
      finish_stream();
      check_done("basic");
      drain("basic", base, 3);

      // 2: restart from DONE, then empty program
      base = n_writes;
      pulse_start();
      chk("restart_done", 32'(done), 32'd0);
      chk("restart_cpu_clr", 32'(cpu_clr), 32'd1);
      chk("restart_cpu_ce", 32'(cpu_ce), 32'd0);
      chk("restart_in_ready", 32'(bus.in_ready), 32'd1);
      send_byte(8'h00);
      send_byte(8'h00);
      finish_stream();
      check_done("empty");
      drain("empty", base, 0);

      // 3: oversize length, then exactly full memory
      base = n_writes;
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h01);
      check_err("oversize");
      repeat (3) idle();
      chk("oversize_hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("oversize_hold_cpu_clr", 32'(cpu_clr), 32'd1);
      drain("oversize", base, 0);

      base = n_writes;
      pulse_start();
      chk("from_err_err", 32'(err), 32'd0);
      send_byte(8'h01);
      send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         d = 16'($urandom);
         send_word(8'(i), d);
      end
      finish_stream();
      check_done("full");
      drain("full", base, 256);
      chk("full_addr_hold", 32'(bus.imem_addr), 32'hFF);

      // 4: flow control: gaps every other cycle, ce low for 5 cycles between AB and CD
      base = n_writes;
      pulse_start();
      send_byte(8'h00); idle();
      send_byte(8'h03); idle();
      send_byte(8'h12); idle();
      exp_q.push_back({8'h00, 16'h1234});
      send_byte(8'h34); idle();
      send_byte(8'hAB); idle();
      exp_q.push_back({8'h01, 16'hABCD});
      ce           = 1'b0;
      bus.in_data  = 8'hCD;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("ce_off_in_ready", 32'(bus.in_ready), 32'd0);
         chk("ce_off_imem_we", 32'(bus.imem_we), 32'd0);
         chk("ce_off_cpu_clr", 32'(cpu_clr), 32'd1);
         @(posedge clk);
         #1;
      end
      ce = 1'b1;
      bus.in_valid = 1'b0;
      idle();
      send_byte(8'hCD); idle();
      send_byte(8'h00); idle();
      exp_q.push_back({8'h02, 16'h0001});
      send_byte(8'h01); idle();
      finish_stream();
      check_done("flow");
      drain("flow", base, 3);

      // 5: asynchronous reset mid-load, then a fresh load
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h12);
      #2;
      clr_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      clr_n = 1'b1;
      idle();
      base = n_writes;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_word(8'h00, 16'hBEEF);
      finish_stream();
      check_done("after_reset");
      drain("after_reset", base, 1);

`ifdef LOADER_CSUM_EN
      // 6: checksum good, then checksum off by one bit
      base = n_writes;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_word(8'h00, 16'h1234);
      send_byte(xor_acc);
      check_done("csum_good");
      drain("csum_good", base, 1);

      base = n_writes;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_word(8'h00, 16'h1234);
      send_byte(xor_acc ^ 8'h01);
      check_err("csum_bad");
      drain("csum_bad", base, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
